// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  typedef logic [ARB_N-1:0]     arb_vec_t;
  typedef logic [ARB_IDX_W-1:0] arb_idx_t;

  // Observation bundle so checkers can bind to FSM state and pointers.
  typedef struct packed {
    arb_state_t state;
    arb_idx_t   ptr;
    arb_idx_t   owner;
  } arb_dbg_t;

  function automatic arb_vec_t arb_onehot(input arb_idx_t idx);
    arb_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping mod 8.
import arb_pkg::*;

module rr_pick (
  input  arb_vec_t req,
  input  arb_idx_t ptr,
  output arb_idx_t pick,
  output logic     any
);

  arb_vec_t rot;
  arb_idx_t off;

  // Rotate so ptr lands on bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    rot = arb_vec_t'({req, req} >> ptr);
    off = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) off = arb_idx_t'(i);
    end
    pick = ptr + off;
    any  = |req;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Registered 8-way round-robin arbiter with hold-until-release grants.
// Optional forced revocation after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
import arb_pkg::*;

module rr_arbiter_8 #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  arb_vec_t req,
  output arb_vec_t grant,
  output logic     grant_valid,
  output logic     timeout,
  output arb_dbg_t dbg
);

  if (N != ARB_N || MAX_HOLD < 2 || MAX_HOLD > 16) begin : g_bad_cfg
    $error("rr_arbiter_8: N must be 8 and MAX_HOLD must be in 2..16");
  end

  arb_state_t state;
  arb_idx_t   ptr;
  arb_idx_t   owner;
  arb_idx_t   pick;
  logic       any;

  rr_pick u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  logic [3:0] hold_cnt;
  logic       timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      ptr         <= '0;
      owner       <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      hold_cnt    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any) begin
            state       <= ARB_GRANT;
            owner       <= pick;
            grant       <= arb_onehot(pick);
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        default: begin
          // A voluntary release takes precedence over a revocation on the same edge.
          if (!req[owner]) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= owner + 3'd1;
          end else if (hold_cnt == HOLD_LAST) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= owner + 3'd1;
            timeout_q   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  assign timeout = timeout_q;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      ptr         <= '0;
      owner       <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any) begin
            state       <= ARB_GRANT;
            owner       <= pick;
            grant       <= arb_onehot(pick);
            grant_valid <= 1'b1;
          end
        end
        default: begin
          // Other request bits are ignored while a grant is held.
          if (!req[owner]) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= owner + 3'd1;
          end
        end
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign dbg.state = state;
  assign dbg.ptr   = ptr;
  assign dbg.owner = owner;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus randomized requesters
// checked against a behavioural round-robin model.
import arb_pkg::*;

module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 4;

  // ---------------- clock / reset ----------------
  logic     clk = 1'b0;
  logic     rst = 1'b1;
  arb_vec_t req = '0;
  arb_vec_t grant;
  logic     grant_valid;
  logic     timeout;
  arb_dbg_t dbg;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.N(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout     (timeout),
    .dbg         (dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks who owns the bus, the rotating priority start and how long the grant has lasted.
  bit m_busy  = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 0;

  task automatic model_edge(input logic [7:0] r, input logic rs);
    if (rs) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        if (r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_busy  = 1;
          m_held  = 1;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % 8;
    end
`ifdef ARB_TIMEOUT_EN
    else if (m_held >= MAX_HOLD) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % 8;
      m_to   = 1;
    end
`endif
    else begin
      m_held++;
    end
  endtask

  function automatic logic [7:0] model_grant();
    logic [7:0] g;
    g = 8'h00;
    if (m_busy) g = 8'(1 << m_owner);
    return g;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic [7:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
    @(posedge clk);
    model_edge(r, rs);
    exp_q.push_back(model_grant());
    #1;
    check_eq("grant", grant, exp_q.pop_front());
    check_eq("grant_valid", {7'd0, grant_valid}, {7'd0, m_busy});
    check_eq("timeout", {7'd0, timeout}, {7'd0, m_to});
    check_eq("ptr", {5'd0, dbg.ptr}, 8'(m_ptr));
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] cur;

  initial begin
    // Reset and single request
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    check_eq("reset_grant", grant, 8'h00);
    repeat (3) step(8'h04, 1'b0);
    check_eq("single_grant", grant, 8'h04);
    step(8'h00, 1'b0);
    check_eq("single_release", grant, 8'h00);
    check_eq("single_ptr", {5'd0, dbg.ptr}, 8'd3);

    // Round-robin fairness between bits 0 and 7 (ptr=3 -> bit 7 first)
    step(8'h81, 1'b0);
    check_eq("rr_first", grant, 8'h80);
    step(8'h01, 1'b0);
    check_eq("rr_gap0", grant, 8'h00);
    step(8'h81, 1'b0);
    check_eq("rr_second", grant, 8'h01);
    step(8'h80, 1'b0);
    check_eq("rr_gap1", grant, 8'h00);
    step(8'h81, 1'b0);
    check_eq("rr_third", grant, 8'h80);

    // Wrap-around: owner 7 releases, ptr wraps to 0
    step(8'h00, 1'b0);
    check_eq("wrap_ptr", {5'd0, dbg.ptr}, 8'd0);
    step(8'h41, 1'b0);
    check_eq("wrap_grant", grant, 8'h01);
    step(8'h00, 1'b0);

    // Hold and ignore
    step(8'h08, 1'b0);
    check_eq("hold_grant", grant, 8'h08);
    repeat (3) step(8'hff, 1'b0);
    check_eq("hold_ignore", grant, 8'h08);
    step(8'hf7, 1'b0);
    check_eq("hold_release", grant, 8'h00);
    step(8'hff, 1'b0);
    check_eq("hold_next", grant, 8'h10);
    step(8'h00, 1'b0);

    // Reset mid-grant
    step(8'h20, 1'b0);
    check_eq("mid_grant", grant, 8'h20);
    step(8'h20, 1'b1);
    check_eq("mid_reset", grant, 8'h00);
    check_eq("mid_ptr", {5'd0, dbg.ptr}, 8'd0);
    step(8'h20, 1'b0);
    check_eq("mid_regrant", grant, 8'h20);
    step(8'h00, 1'b0);

    // Long hold on two requesters
    step(8'h00, 1'b1);
    repeat (4) step(8'h03, 1'b0);
    check_eq("long_grant", grant, 8'h01);
    step(8'h03, 1'b0);
`ifdef ARB_TIMEOUT_EN
    check_eq("to_pulse", {7'd0, timeout}, 8'd1);
    check_eq("to_grant", grant, 8'h00);
    step(8'h03, 1'b0);
    check_eq("to_next", grant, 8'h02);
    check_eq("to_clear", {7'd0, timeout}, 8'd0);
`else
    check_eq("nto_grant", grant, 8'h01);
    check_eq("nto_flag", {7'd0, timeout}, 8'd0);
`endif
    step(8'h00, 1'b0);

    // Randomized requesters: each holds its line for a random while, occasional reset
    cur = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if (cur[b]) begin
          if ($urandom_range(0, 3) == 0) cur[b] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          cur[b] = 1'b1;
        end
      end
      step(cur, ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Registered round-robin arbiter that reduces up to eight simultaneous request lines to a single one-hot grant vector. It sits directly upstream of the 8-to-3 encoder. Its `grant` output drives the encoder's 8-bit input, so the encoder only ever sees all-zero or exactly one bit set, and its `valid` output is always meaningful. Grants are held until the winning requester releases, and fairness comes from a rotating priority pointer.

## Interface
- `N`, 8: number of request lines. Fixed at 8 to match the encoder; other values are not supported.
- `MAX_HOLD`, 16: maximum grant length in cycles. Used only when `ARB_TIMEOUT_EN` is defined; must be ≥2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  8: request lines, level-sensitive. Bit i is held high by requester i until it has finished.
- `grant`  out  8: registered one-hot grant, or all-zero. Feeds the encoder input.
- `grant_valid`  out  1: registered; high exactly when `grant` is non-zero.
- `timeout`  out  1: registered single-cycle pulse when a grant is forcibly revoked. Constant 0 when the macro is absent.

## Operation
- **State machine.** States are IDLE and GRANT.
- **Internal registers.**
  - `ptr` (3 bits): highest-priority index for the next arbitration.
  - `owner` (3 bits): index currently granted.
  - `hold_cnt` (4 bits): present only under the macro.
- **IDLE.**
  - With `req`==0: stay in IDLE; `grant`=0.
  - Otherwise: pick the first set bit of `req` searching ptr, ptr+1, …, 7, 0, … (wraps mod 8).
  - Then go to GRANT, with `owner`=pick, `grant`=1<<pick and `grant_valid`=1.
- **GRANT.**
  - While `req[owner]`=1: hold `grant` unchanged. Other request bits are ignored.
  - When `req[owner]`=0: go to IDLE and clear `grant`/`grant_valid`. Set `ptr`=(owner+1) mod 8, so wrap-around means owner 7 sets ptr to 0.
- **Mandatory gap.** At least one IDLE cycle with `grant`=0 separates any two grants. The encoder therefore outputs valid=0 between owners, and back-to-back grants never overlap.
- **Simultaneous release and new request.** If the owner drops in the same cycle another line rises, the release is processed first (one cycle grant=0). The new line then competes in the following IDLE evaluation.
- **Re-request by the previous owner.** It has the lowest priority in the next arbitration because of the `ptr` rotation.
- **Reset.** While `rst`=1 at an edge, regardless of state or `req` (including mid-grant):
  - `grant`=0, `grant_valid`=0, `timeout`=0;
  - state is IDLE;
  - `ptr`=0, `owner`=0, `hold_cnt`=0.
- **Priority after reset.** The first arbitration after reset gives `req[0]` the highest priority.

## Timing
- Inputs are sampled on the rising edge and all outputs are registered.
- **Grant latency.** A `req` seen high at edge k in IDLE produces `grant` at edge k (visible in cycle k+1). That is 1 cycle from sampled request to grant.
- **Release latency.** A `req[owner]` sampled low at edge k clears `grant` at edge k. The earliest next grant is at edge k+1.
- **Throughput.** A maximum of one grant per 2 cycles when requests are continuous and each lasts 1 cycle.

## Configuration
- **`ARB_TIMEOUT_EN` defined.**
  - `hold_cnt` resets to 0 on entry to GRANT and increments every GRANT cycle.
  - When `hold_cnt`==MAX_HOLD-1 and `req[owner]` is still 1, the next edge revokes the grant:
    - go to IDLE with `grant`=0;
    - `timeout`=1 for exactly that one cycle;
    - `ptr`=owner+1.
  - The revoked requester, if still requesting, re-competes with the lowest priority.
  - Maximum grant length is MAX_HOLD cycles.
- **`ARB_TIMEOUT_EN` undefined.** No counter is present; grants are unbounded; `timeout` is tied to 0.

## Structure
- **Package `arb_pkg`:**
  - `ARB_N`=8 and `ARB_IDX_W`=3;
  - `typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t`;
  - `typedef logic [ARB_N-1:0] arb_vec_t`.
- **Sub-module `rr_pick`:** combinational. Inputs are `req[7:0]` and `ptr[2:0]`; outputs are `pick[2:0]` and `any`. It implements the rotate, priority-select and un-rotate search. The top level holds the FSM, the registers and the optional counter.

## Test plan
- **Reset and single request.**
  - Stimulus: `rst`=1 for 2 cycles, then `req`=00000100 held for 3 cycles, then 0.
  - Required: `grant`=0 during reset; then `grant`=00000100 for 3 cycles, then 0; `ptr` becomes 3.
- **Round-robin fairness.**
  - Stimulus: `req`=10000001, each grantee releasing after 1 cycle and re-asserting.
  - Required: grant order 00000001, 10000000, 00000001, …, each separated by one all-zero cycle.
- **Wrap-around.**
  - Stimulus: grant to bit 7, release, then `req`=01000001.
  - Required: the next grant is 00000001 (ptr wrapped to 0).
- **Hold and ignore.**
  - Stimulus: bit 3 granted; `req` changes to 11111111 while bit 3 is held.
  - Required: `grant` stays 00001000 until `req[3]` drops; the next grant is 00010000.
- **Reset mid-grant.**
  - Stimulus: bit 5 granted; `rst`=1 for one cycle with `req`=00100000 still high.
  - Required: `grant`=0 the next cycle; the following cycle `grant`=00100000 (ptr=0, bit 5 is the only requester).
- **Timeout (macro on, MAX_HOLD=4).**
  - Stimulus: `req`=00000011 held.
  - Required: 00000001 for 4 cycles, then `timeout`=1 with `grant`=0 for 1 cycle, then 00000010.
